sll_arbiter: RTL and testbench
==============================

# sll_arbiter

Two-requester front end for the shared 32-bit logical-left barrel shifter (`sll_barrel`). It arbitrates round-robin between two requesters and feeds the winner's operand and shift amount through the single shifter. Results are buffered in a small output FIFO with a valid/ready handshake, so the ALU shift path and the secondary requester share one shifter without a combinational path from response back-pressure to request acceptance.

## Interface
- `OUT_DEPTH`, default 2: output FIFO entries; power of two, ≥2.
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req0_valid` input 1: requester 0 has an operation.
- `req0_ready` output 1: requester 0's operation is accepted this cycle.
- `req0_a` input 32: requester 0 operand.
- `req0_amt` input 5: requester 0 shift amount.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_amt`: same as requester 0, for requester 1.
- `resp_valid` output 1: FIFO head holds a result.
- `resp_ready` input 1: consumer accepts the head.
- `resp_data` output 32: head result, `A << amt`.
- `resp_id` output 1: index of the requester that produced the head.
- `busy` output 1: FIFO count is nonzero.

## Operation
- Acceptance:
  - `space = (count < OUT_DEPTH)`, computed from registered count only. `resp_ready` never affects `reqX_ready` in the same cycle.
  - Grant when only one `reqX_valid` is high: that requester.
  - Grant when both are high: the requester that is not `last_grant`.
  - `reqX_ready = space && grant==X`. At most one ready is high per cycle.
  - A transfer happens when `reqX_valid && reqX_ready`.
- Pointer: `last_grant` updates to X only on a transfer. It holds when no transfer occurs, including when `space` is low.
- Datapath: the winner's `a`/`amt` are muxed into one `sll_barrel` instance. `{id, a << amt}` is written to the FIFO tail on the transfer edge.
- Width rules:
  - Bits shifted past bit 31 are discarded; zeros fill from the LSB.
  - `amt` = 0 passes `a` unchanged. `amt` = 31 leaves only `a[0]` at bit 31.
- Response: the head is presented on `resp_*`. A pop occurs when `resp_valid && resp_ready`.
- Simultaneous push and pop: allowed when `count < OUT_DEPTH`; count is unchanged and both pointers advance.
- Full: with `count == OUT_DEPTH`, both readies are low even if a pop occurs that cycle. This costs one bubble per full event, by design.
- Pointers: read and write pointers are `$clog2(OUT_DEPTH)` bits and wrap modulo `OUT_DEPTH`. Count is `$clog2(OUT_DEPTH)+1` bits.
- Requester rules:
  - Requesters hold `valid`, `a` and `amt` stable until ready.
  - If a requester violates this, the value sampled on the transfer edge is the one used. No assertion inside the block.
- Reset (async assert, sync-safe deassert by the top level):
  - count = 0, pointers = 0, `last_grant` = 1, so req0 wins the first tie.
  - Outputs: `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0, `busy` = 0.
  - Reset mid-operation discards all FIFO contents; no result is emitted.

## Timing
- Latency: transfer at edge N into an empty FIFO → `resp_valid` high in cycle N+1.
- Throughput: 1 result/cycle when `resp_ready` is held high and the FIFO never fills.
- `reqX_ready` depends only on registered state and both `reqX_valid`.
- `resp_*` are registered FIFO outputs; the head is read from the storage array at the registered read pointer.
- Critical path: grant mux → `sll_barrel` (5 mux levels) → FIFO write data. No retiming required at target clock.

## Structure
- Shared package (`alu_pkg`):
  - `SHAMT_W` = 5, `DATA_W` = 32.
  - Requester ID encoding: `REQ_ALU` = 0, `REQ_AUX` = 1.
- Sub-module `sll_resp_fifo`: parameterised by `OUT_DEPTH` and entry width `DATA_W+1`. Interface is push/pop/full/empty/count/head.
- `sll_arbiter` holds the round-robin grant logic, `last_grant`, the operand mux and the shifter instance only.

## Test plan
- After reset: with no requests, `resp_valid`=0 and both readies are 0. Assert req0 with `a`=0x0000_0001, `amt`=31 → `req0_ready`=1, then `resp_data`=0x8000_0000, `resp_id`=0 the next cycle.
- Both requesters valid continuously, `resp_ready`=1 → grants alternate 0,1,0,1. Results: req0 `a`=0xFFFF_FFFF, `amt`=4 → 0xFFFF_FFF0; req1 `a`=0x1234_5678, `amt`=16 → 0x5678_0000.
- `resp_ready`=0 with 3 back-to-back req0 requests → two accepted, `req0_ready` low on the third. Raise `resp_ready` → drains in order, then the third is accepted one cycle after the first pop.
- `amt`=0 passes `a` unchanged (`a`=0xDEAD_BEEF → 0xDEAD_BEEF). An exhaustive `amt` sweep on 0xA5A5_A5A5 matches the reference model.
- Assert `reset_n` low with 2 entries queued → `resp_valid` drops immediately (asynchronous). After release, `busy`=0 and a tie goes to req0.
- Only req1 valid for 4 cycles, then both valid → req0 wins the first tie, because the pointer points at req1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths and requester encodings for the shift path.
package alu_pkg;
  localparam int SHAMT_W = 5;
  localparam int DATA_W  = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_AUX = 1'b1
  } req_id_e;

  typedef struct packed {
    req_id_e             id;
    logic [DATA_W-1:0]   data;
  } resp_entry_t;
endpackage

// File: rtl/sll_barrel.sv
// 32-bit logical-left barrel shifter: one 2:1 mux level per shift-amount bit.
module sll_barrel
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] amt,
  output logic [DATA_W-1:0]  y
);
  logic [DATA_W-1:0] stg [0:SHAMT_W];

  assign stg[0] = a;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_lvl
    localparam int SH = 1 << i;
    assign stg[i+1] = amt[i] ? {stg[i][DATA_W-1-SH:0], {SH{1'b0}}} : stg[i];
  end

  assign y = stg[SHAMT_W];
endmodule

// File: rtl/sll_resp_fifo.sv
// Result FIFO; head is the storage entry at the registered read pointer, zeroed while empty.
module sll_resp_fifo
  import alu_pkg::*;
#(
  parameter int OUT_DEPTH = 2,
  parameter int ENTRY_W   = DATA_W + 1,
  localparam int PTR_W    = $clog2(OUT_DEPTH),
  localparam int CNT_W    = $clog2(OUT_DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);
  logic [ENTRY_W-1:0] mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  always_comb begin
    full    = (count_q == CNT_W'(OUT_DEPTH));
    empty   = (count_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage holds data only; stale entries are masked by the empty gate below.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  assign head  = empty ? '0 : mem_q[rptr_q];
  assign count = count_q;
endmodule

// File: rtl/sll_arbiter.sv
// Round-robin front end sharing one sll_barrel between two requesters, results queued in sll_resp_fifo.
module sll_arbiter
  import alu_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [SHAMT_W-1:0] req0_amt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [SHAMT_W-1:0] req1_amt,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_data,
  output logic               resp_id,
  output logic               busy
);
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  req_id_e            last_grant_q, last_grant_d;
  logic               gnt0, gnt1, space, push;
  logic [DATA_W-1:0]  sel_a, shifted;
  logic [SHAMT_W-1:0] sel_amt;
  resp_entry_t        push_entry, head_entry;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  // Acceptance uses only registered FIFO state, never resp_ready.
  always_comb begin
    space        = !fifo_full;
    gnt0         = req0_valid && (!req1_valid || last_grant_q == REQ_AUX);
    gnt1         = req1_valid && (!req0_valid || last_grant_q == REQ_ALU);
    req0_ready   = space && gnt0;
    req1_ready   = space && gnt1;
    push         = req0_ready || req1_ready;
    sel_a        = gnt1 ? req1_a   : req0_a;
    sel_amt      = gnt1 ? req1_amt : req0_amt;
    last_grant_d = last_grant_q;
    if (req0_ready)      last_grant_d = REQ_ALU;
    else if (req1_ready) last_grant_d = REQ_AUX;
    push_entry.id   = gnt1 ? REQ_AUX : REQ_ALU;
    push_entry.data = shifted;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_grant_q <= REQ_AUX;
    else          last_grant_q <= last_grant_d;
  end

  sll_barrel u_barrel (
    .a   (sel_a),
    .amt (sel_amt),
    .y   (shifted)
  );

  sll_resp_fifo #(
    .OUT_DEPTH (OUT_DEPTH),
    .ENTRY_W   (DATA_W + 1)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (resp_ready),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign resp_valid = !fifo_empty;
  assign resp_data  = head_entry.data;
  assign resp_id    = head_entry.id;
  assign busy       = (fifo_count != '0);
endmodule

// File: tb/tb_sll_arbiter.sv
// Directed bench for sll_arbiter: reset, grant alternation, full/back-pressure, shift sweep, async reset.
module tb_sll_arbiter;
  logic        clock, reset_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req1_a, resp_data;
  logic [4:0]  req0_amt, req1_amt;
  logic        resp_valid, resp_ready, resp_id, busy;
  int          checks, failures;

  sll_arbiter #(.OUT_DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_amt(req1_amt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%0b exp=0", resp_valid); end
    checks++; if (resp_data !== 32'h0) begin failures++; $display("FAIL rst_resp_data got=%h exp=00000000", resp_data); end
    checks++; if (resp_id !== 1'b0) begin failures++; $display("FAIL rst_resp_id got=%0b exp=0", resp_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL idle_readies got=%0b%0b exp=00", req0_ready, req1_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL idle_resp_valid got=%0b exp=0", resp_valid); end
  endtask

  task automatic test_first();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h0000_0001; req0_amt = 5'd31;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL first_ready got=%0b%0b exp=10", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%0b exp=1", resp_valid); end
    checks++; if (resp_data !== 32'h8000_0000) begin failures++; $display("FAIL first_data got=%h exp=80000000", resp_data); end
    checks++; if (resp_id !== 1'b0) begin failures++; $display("FAIL first_id got=%0b exp=0", resp_id); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL first_busy got=%0b exp=1", busy); end
    tick();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL first_drain got=%0b%0b exp=00", resp_valid, busy); end
  endtask

  task automatic test_alternate();
    logic [31:0] exp_d;
    apply_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_amt = 5'd4;
    req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_amt = 5'd16;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        failures++; $display("FAIL alt_grant[%0d] got=%0b%0b exp_req=%0d", i, req0_ready, req1_ready, i % 2); end
      tick();
      exp_d = (i % 2 == 0) ? 32'hFFFF_FFF0 : 32'h5678_0000;
      checks++; if (resp_valid !== 1'b1 || resp_data !== exp_d || resp_id !== 1'(i % 2)) begin
        failures++; $display("FAIL alt_resp[%0d] got=%0b/%h/%0b exp=1/%h/%0d", i, resp_valid, resp_data, resp_id, exp_d, i % 2); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL alt_drain_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_full();
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_amt = 5'd1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL full_acc1 got=%0b exp=1", req0_ready); end
    tick();
    req0_a = 32'd2;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL full_acc2 got=%0b exp=1", req0_ready); end
    tick();
    req0_a = 32'd3;
    #1;
    checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL full_block got=%0b exp=0", req0_ready); end
    checks++; if (resp_data !== 32'd2 || busy !== 1'b1) begin failures++; $display("FAIL full_head got=%h/%0b exp=00000002/1", resp_data, busy); end
    tick();
    checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL full_hold got=%0b exp=0", req0_ready); end
    resp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL full_bubble got=%0b exp=0", req0_ready); end
    tick();
    checks++; if (resp_data !== 32'd4 || req0_ready !== 1'b1) begin failures++; $display("FAIL full_pop1 got=%h/%0b exp=00000004/1", resp_data, req0_ready); end
    tick();
    req0_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd6 || resp_id !== 1'b0) begin
      failures++; $display("FAIL full_third got=%0b/%h/%0b exp=1/00000006/0", resp_valid, resp_data, resp_id); end
    tick();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL full_drain got=%0b%0b exp=00", resp_valid, busy); end
  endtask

  task automatic test_amt();
    logic [31:0] pat, exp_d;
    resp_ready = 1'b1;
    req1_valid = 1'b1; req1_a = 32'hDEAD_BEEF; req1_amt = 5'd0;
    tick();
    checks++; if (resp_data !== 32'hDEAD_BEEF || resp_id !== 1'b1) begin
      failures++; $display("FAIL amt0 got=%h/%0b exp=deadbeef/1", resp_data, resp_id); end
    pat = 32'hA5A5_A5A5;
    req1_a = pat;
    for (int i = 0; i < 32; i++) begin
      req1_amt = 5'(i);
      tick();
      exp_d = pat << i;
      checks++; if (resp_valid !== 1'b1 || resp_data !== exp_d) begin
        failures++; $display("FAIL sweep[%0d] got=%0b/%h exp=1/%h", i, resp_valid, resp_data, exp_d); end
    end
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd7; req0_amt = 5'd0;
    tick();
    tick();
    req0_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_queued got=%0b%0b exp=11", resp_valid, busy); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== 32'h0) begin
      failures++; $display("FAIL mid_async got=%0b/%0b/%h exp=0/0/00000000", resp_valid, busy, resp_data); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL mid_after got=%0b%0b exp=00", busy, resp_valid); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL mid_tie got=%0b%0b exp=10", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
  endtask

  task automatic test_pointer();
    resp_ready = 1'b1;
    req1_valid = 1'b1; req1_a = 32'h0000_0003; req1_amt = 5'd2;
    req0_a = 32'h0000_0001; req0_amt = 5'd8;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failures++; $display("FAIL solo1[%0d] got=%0b%0b exp=01", i, req0_ready, req1_ready); end
      tick();
    end
    checks++; if (resp_data !== 32'h0000_000C || resp_id !== 1'b1) begin failures++; $display("FAIL solo1_data got=%h/%0b exp=0000000c/1", resp_data, resp_id); end
    req0_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL ptr_tie got=%0b%0b exp=10", req0_ready, req1_ready); end
    tick();
    checks++; if (resp_data !== 32'h0000_0100 || resp_id !== 1'b0) begin failures++; $display("FAIL ptr_data got=%h/%0b exp=00000100/0", resp_data, resp_id); end
    #1;
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failures++; $display("FAIL ptr_next got=%0b%0b exp=01", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_amt = '0;
    req1_valid = 1'b0; req1_a = '0; req1_amt = '0;
    resp_ready = 1'b0;
    test_reset();
    test_first();
    test_alternate();
    test_full();
    test_amt();
    test_reset_mid();
    test_pointer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
